// File: rtl/spi_slave_if_pkg.sv
// Shared definitions for the SPI slave front end and the RAM bench:
// FSM state encodings, command codes and default widths.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHK_CMD   = 3'd1,
        ST_WRITE     = 3'd2,
        ST_READ_ADD  = 3'd3,
        ST_READ_DATA = 3'd4
    } spi_state_e;

    // din[9:8] command codes as seen by the RAM
    localparam logic [1:0] WRITE_ADD  = 2'b00;
    localparam logic [1:0] WRITE_DATA = 2'b01;
    localparam logic [1:0] READ_ADD   = 2'b10;
    localparam logic [1:0] READ_DATA  = 2'b11;

    localparam int RX_W_DEF = 10;
    localparam int TX_W_DEF = 8;

endpackage

// File: rtl/spi_slave_if_tx_shifter.sv
// Load/shift-out register for the read byte: MSB goes out on the load edge,
// the remaining bits on the following edges, then the output returns to 0.
module spi_tx_shifter
    import spi_pkg::*;
#(
    parameter int W = TX_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    output logic         o_bit,
    output logic         o_last
);

    localparam int CW = $clog2(W);

    logic [W-1:0]  r_sr;
    logic [CW-1:0] r_cnt;
    logic          r_busy;

    // High while the final bit is on the line; the next edge ends the byte.
    assign o_last = r_busy && (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_sr   <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            o_bit  <= 1'b0;
        end else if (i_load) begin
            o_bit  <= i_data[W-1];
            r_sr   <= {i_data[W-2:0], 1'b0};
            r_cnt  <= CW'(W - 1);
            r_busy <= 1'b1;
        end else if (r_busy) begin
            if (r_cnt != '0) begin
                o_bit <= r_sr[W-1];
                r_sr  <= {r_sr[W-2:0], 1'b0};
                r_cnt <= r_cnt - 1'b1;
            end else begin
                o_bit  <= 1'b0;
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises SS_n-gated MOSI frames into RAM words
// and serialises the RAM's read byte back out on MISO.
module spi_slave_if
    import spi_pkg::*;
#(
    parameter int RX_W = RX_W_DEF,
    parameter int TX_W = TX_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            SS_n,
    input  logic            MOSI,
    output logic            MISO,
    output logic [RX_W-1:0] rx_data,
    output logic            rx_valid,
    input  logic [TX_W-1:0] tx_data,
    input  logic            tx_valid
);

    localparam logic [3:0] LAST    = 4'(RX_W - 1);
    localparam logic [3:0] LAST_M1 = 4'(RX_W - 2);

    spi_state_e r_state;
    logic [3:0] r_cnt;
    logic       r_rd_addr_done;
    logic       r_tx_cap;
    logic       w_load;
    logic       w_last;

    // Capture only the first tx_valid after the word has been handed over.
    assign w_load = (r_state == ST_READ_DATA) && !SS_n && (r_cnt == LAST)
                    && !r_tx_cap && tx_valid;

    spi_tx_shifter #(.W(TX_W)) u_tx (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (SS_n),
        .i_load (w_load),
        .i_data (tx_data),
        .o_bit  (MISO),
        .o_last (w_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_rd_addr_done <= 1'b0;
            r_tx_cap       <= 1'b0;
            rx_data        <= '0;
            rx_valid       <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (SS_n) begin
                // Abort wins over everything, including a 10th bit on this edge.
                r_state  <= ST_IDLE;
                r_cnt    <= '0;
                r_tx_cap <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: r_state <= ST_CHK_CMD;
                    ST_CHK_CMD: begin
                        rx_data[RX_W-1] <= MOSI;
                        r_cnt           <= '0;
                        r_tx_cap        <= 1'b0;
                        if (!MOSI)
                            r_state <= ST_WRITE;
                        else if (r_rd_addr_done)
                            r_state <= ST_READ_DATA;
                        else
                            r_state <= ST_READ_ADD;
                    end
                    default: begin
                        if (r_cnt != LAST) begin
                            rx_data[RX_W-2:0] <= {rx_data[RX_W-3:0], MOSI};
                            r_cnt             <= r_cnt + 4'd1;
                            if (r_cnt == LAST_M1) begin
                                rx_valid <= 1'b1;
                                if (r_state == ST_READ_ADD)
                                    r_rd_addr_done <= 1'b1;
                            end
                        end
                        if (w_load)
                            r_tx_cap <= 1'b1;
                        if (w_last)
                            r_rd_addr_done <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_if.sv
// Scoreboard bench for spi_slave_if: expected RAM words and MISO bits are
// queued as frames are driven and compared as the DUT produces them.
module tb_spi_slave_if;
    import spi_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       SS_n = 1'b1;
    logic       MOSI = 1'b0;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [9:0] exp_rx[$];
    logic       m_rad = 1'b0;
    logic [7:0] ram_byte = 8'h00;
    logic       ram_pend = 1'b0;
    int         ram_hold = 0;

    spi_slave_if dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock: let the posedge happen, then sample on the falling edge
    // and run the RAM reply model.
    task automatic tick(input logic exp_miso);
        @(posedge clk);
        @(negedge clk);
        chk("miso", MISO, exp_miso);
        if (rx_valid) begin
            if (exp_rx.size() == 0)
                chk("rx_extra", 1, 0);
            else
                chk("rx_data", rx_data, exp_rx.pop_front());
        end
        if (ram_hold > 0) begin
            ram_hold--;
            if (ram_hold == 0) tx_valid = 1'b0;
        end
        if (ram_pend) begin
            tx_valid = 1'b1;
            tx_data  = ram_byte;
            ram_pend = 1'b0;
            ram_hold = 3;
        end
        if (rx_valid && rx_data[9:8] == READ_DATA) ram_pend = 1'b1;
    endtask

    // nbits < 10 aborts after that many bits; rst_at > 0 pulses reset on that hold cycle.
    task automatic frame(input logic [9:0] w, input int nbits, input int hold, input int rst_at);
        logic rd;
        rd = (nbits == 10) && w[9] && m_rad;
        SS_n = 1'b0;
        MOSI = 1'b1;
        tick(1'b0);
        for (int i = 0; i < nbits; i++) begin
            MOSI = w[9-i];
            if (i == 9) exp_rx.push_back(w);
            tick(1'b0);
        end
        if (nbits == 10 && w[9] && !m_rad) m_rad = 1'b1;
        for (int k = 1; k <= hold; k++) begin
            MOSI = 1'($urandom_range(0, 1));
            if (k == rst_at) begin
                rst_n = 1'b0;
                tick(1'b0);
                rst_n = 1'b1;
                chk("rst_rx_valid", rx_valid, 0);
                chk("rst_rx_data", rx_data, 0);
                m_rad = 1'b0;
                break;
            end
            tick((rd && k >= 2 && k <= 9) ? ram_byte[9-k] : 1'b0);
            if (rd && k == 10) m_rad = 1'b0;
        end
        SS_n = 1'b1;
        MOSI = (nbits < 10) ? w[9-nbits] : 1'b0;
        tick(1'b0);
    endtask

    initial begin
        logic [9:0] w;
        for (int i = 0; i < 3; i++) tick(1'b0);
        chk("reset_rx_valid", rx_valid, 0);
        chk("reset_rx_data", rx_data, 0);
        rst_n = 1'b1;
        tick(1'b0);

        frame({WRITE_ADD, 8'hA5}, 10, 3, 0);
        // Reset pulse between edges must not take effect.
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick(1'b0);
        chk("no_edge_rst", rx_data, 10'h0A5);

        frame({WRITE_DATA, 8'h3C}, 10, 3, 0);

        ram_byte = 8'h3C;
        frame({READ_ADD, 8'hA5}, 10, 3, 0);
        frame({READ_DATA, 8'h00}, 10, 12, 0);

        frame({WRITE_ADD, 8'h77}, 6, 0, 0);
        frame({WRITE_ADD, 8'h11}, 10, 2, 0);
        frame({WRITE_DATA, 8'h55}, 9, 0, 0);

        frame({READ_ADD, 8'h40}, 10, 2, 0);
        ram_byte = 8'hC9;
        frame({READ_DATA, 8'h00}, 10, 4, 0);
        ram_byte = 8'h96;
        frame({READ_DATA, 8'h00}, 10, 12, 0);

        frame({READ_ADD, 8'h21}, 10, 2, 0);
        ram_byte = 8'hE7;
        frame({READ_DATA, 8'h00}, 10, 12, 5);
        frame({READ_DATA, 8'h12}, 10, 6, 0);
        ram_byte = 8'h5A;
        frame({READ_DATA, 8'h00}, 10, 12, 0);

        for (int n = 0; n < 4; n++) begin
            w = 10'($urandom_range(0, 511));
            frame(w, 10, 2, 0);
        end

        chk("rx_missing", exp_rx.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
